// File: rtl/spi_gyro_responder.sv
// SPI mode-3 slave emulating a three-axis gyro register map (WHO_AM_I, CTRL1-5, STATUS, XYZ).
// All SPI pins are oversampled and edge-detected in the clk domain.
module spi_gyro_responder #(
   parameter logic [7:0]  WHO_AM_I_VAL = 8'hD3,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_x_data,
   input  logic [15:0] i_y_data,
   input  logic [15:0] i_z_data,
   input  logic        i_sample_valid,
   input  logic        i_sclk,
   input  logic        i_ss,
   input  logic        i_mosi,
   output logic        o_miso,
   output logic        o_miso_en,
   output logic [7:0]  o_ctrl_reg1,
   output logic [7:0]  o_ctrl_reg2,
   output logic [7:0]  o_ctrl_reg3,
   output logic [7:0]  o_ctrl_reg4,
   output logic [7:0]  o_ctrl_reg5,
   output logic        o_wr_strobe,
   output logic [5:0]  o_wr_addr
);

   typedef enum logic [1:0] {StIdle, StCmd, StData} state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
   logic                   r_sclk_d, r_ss_d;
   logic                   w_sclk_s, w_ss_s, w_mosi_s;
   logic                   w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_bit_cnt;
   logic [6:0]  r_rx;
   logic [7:0]  w_rx_byte;
   logic [7:0]  r_tx;
   logic        r_rw, r_ms;
   logic [5:0]  r_addr, w_addr_nxt, w_rd_addr;
   logic [7:0]  w_rd_data;
   logic        w_byte_done, w_wr_ok;

   logic        r_miso, r_miso_en, r_wr_strobe;
   logic [5:0]  r_wr_addr;
   logic [7:0]  r_ctrl1, r_ctrl2, r_ctrl3, r_ctrl4, r_ctrl5;
   logic [15:0] r_snap_x, r_snap_y, r_snap_z;
   logic        r_zyxda, r_zyxor;

   // Synchronizers reset to the SPI idle levels so reset release makes no false edges
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_sync <= '1;
         r_ss_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b1;
         r_ss_d      <= 1'b1;
         r_miso_en   <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
         r_sclk_d    <= w_sclk_s;
         r_ss_d      <= w_ss_s;
         r_miso_en   <= ~w_ss_s;
      end
   end

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_ss_rise   = w_ss_s & ~r_ss_d;
   assign w_ss_fall   = ~w_ss_s & r_ss_d;

   assign w_rx_byte   = {r_rx, w_mosi_s};
   // An ss rising edge beats a coincident byte-completing sclk edge
   assign w_byte_done = (r_state != StIdle) & ~w_ss_rise & w_sclk_rise & (r_bit_cnt == 3'd7);
   assign w_addr_nxt  = r_ms ? r_addr + 6'd1 : r_addr;
   assign w_rd_addr   = (r_state == StCmd) ? w_rx_byte[5:0] : w_addr_nxt;
   assign w_wr_ok     = (r_addr >= 6'h20) && (r_addr <= 6'h24);

   always_comb begin
      w_rd_data = 8'h00;
      case (w_rd_addr)
         6'h0F:   w_rd_data = WHO_AM_I_VAL;
         6'h20:   w_rd_data = r_ctrl1;
         6'h21:   w_rd_data = r_ctrl2;
         6'h22:   w_rd_data = r_ctrl3;
         6'h23:   w_rd_data = r_ctrl4;
         6'h24:   w_rd_data = r_ctrl5;
         6'h27:   w_rd_data = {r_zyxor, 3'b000, r_zyxda, 3'b000};
         6'h28:   w_rd_data = r_snap_x[7:0];
         6'h29:   w_rd_data = r_snap_x[15:8];
         6'h2A:   w_rd_data = r_snap_y[7:0];
         6'h2B:   w_rd_data = r_snap_y[15:8];
         6'h2C:   w_rd_data = r_snap_z[7:0];
         6'h2D:   w_rd_data = r_snap_z[15:8];
         default: w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_ss_fall) w_state_nxt = StCmd;
         end
         StCmd: begin
            if (w_ss_rise)        w_state_nxt = StIdle;
            else if (w_byte_done) w_state_nxt = StData;
         end
         StData: begin
            if (w_ss_rise) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Shift datapath: rx on rising sclk, tx on falling sclk
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bit_cnt <= '0;
         r_rx      <= '0;
         r_tx      <= '0;
         r_rw      <= 1'b0;
         r_ms      <= 1'b0;
         r_addr    <= '0;
         r_miso    <= 1'b1;
      end else if (w_ss_fall) begin
         r_bit_cnt <= '0;
         r_tx      <= '0;
      end else if (w_ss_rise) begin
         r_bit_cnt <= '0;
         r_miso    <= 1'b1;
      end else if (r_state != StIdle) begin
         if (w_sclk_rise) begin
            r_rx      <= w_rx_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
               if (r_state == StCmd) begin
                  r_rw   <= w_rx_byte[7];
                  r_ms   <= w_rx_byte[6];
                  r_addr <= w_rx_byte[5:0];
                  r_tx   <= w_rx_byte[7] ? w_rd_data : 8'h00;
               end else begin
                  r_addr <= w_addr_nxt;
                  r_tx   <= r_rw ? w_rd_data : 8'h00;
               end
            end
         end else if (w_sclk_fall) begin
            r_miso <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_ctrl1     <= 8'h07;
         r_ctrl2     <= 8'h00;
         r_ctrl3     <= 8'h00;
         r_ctrl4     <= 8'h00;
         r_ctrl5     <= 8'h00;
      end else begin
         r_wr_strobe <= 1'b0;
         if (w_byte_done && (r_state == StData) && !r_rw && w_wr_ok) begin
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= r_addr;
            case (r_addr[2:0])
               3'd0:    r_ctrl1 <= w_rx_byte;
               3'd1:    r_ctrl2 <= w_rx_byte;
               3'd2:    r_ctrl3 <= w_rx_byte;
               3'd3:    r_ctrl4 <= w_rx_byte;
               3'd4:    r_ctrl5 <= w_rx_byte;
               default: ;
            endcase
         end
      end
   end

   // Snapshot clears STATUS, but a coincident sample_valid still sets it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_snap_x <= '0;
         r_snap_y <= '0;
         r_snap_z <= '0;
         r_zyxda  <= 1'b0;
         r_zyxor  <= 1'b0;
      end else if (w_ss_fall) begin
         r_snap_x <= i_x_data;
         r_snap_y <= i_y_data;
         r_snap_z <= i_z_data;
         r_zyxda  <= i_sample_valid;
         r_zyxor  <= i_sample_valid & r_zyxda;
      end else if (i_sample_valid) begin
         r_zyxda  <= 1'b1;
         r_zyxor  <= r_zyxor | r_zyxda;
      end
   end

   assign o_miso      = r_miso;
   assign o_miso_en   = r_miso_en;
   assign o_ctrl_reg1 = r_ctrl1;
   assign o_ctrl_reg2 = r_ctrl2;
   assign o_ctrl_reg3 = r_ctrl3;
   assign o_ctrl_reg4 = r_ctrl4;
   assign o_ctrl_reg5 = r_ctrl5;
   assign o_wr_strobe = r_wr_strobe;
   assign o_wr_addr   = r_wr_addr;

endmodule

// File: tb/tb_spi_gyro_responder.sv
// Bench for spi_gyro_responder: SPI master driver, transaction-level register model and a
// per-cycle compare of miso_en / wr_strobe / wr_addr / ctrl outputs against scheduled events.
module tb_spi_gyro_responder;

   localparam int SYNC = 2;
   localparam int LAT  = SYNC + 1;
   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] x_data = '0, y_data = '0, z_data = '0;
   logic        sample_valid = 1'b0;
   logic        sclk = 1'b1, ss = 1'b1, mosi = 1'b0;
   logic        miso, miso_en, wr_strobe;
   logic [7:0]  c1, c2, c3, c4, c5;
   logic [5:0]  wr_addr;

   spi_gyro_responder #(.WHO_AM_I_VAL(8'hD3), .SYNC_STAGES(SYNC)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_x_data       (x_data),
      .i_y_data       (y_data),
      .i_z_data       (z_data),
      .i_sample_valid (sample_valid),
      .i_sclk         (sclk),
      .i_ss           (ss),
      .i_mosi         (mosi),
      .o_miso         (miso),
      .o_miso_en      (miso_en),
      .o_ctrl_reg1    (c1),
      .o_ctrl_reg2    (c2),
      .o_ctrl_reg3    (c3),
      .o_ctrl_reg4    (c4),
      .o_ctrl_reg5    (c5),
      .o_wr_strobe    (wr_strobe),
      .o_wr_addr      (wr_addr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_strobe = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Transaction-level model of the register map
   logic [7:0]  m_ctrl [0:4];
   logic [15:0] m_sx, m_sy, m_sz;
   logic        m_da, m_or;
   logic [15:0] sv_x, sv_y, sv_z;

   // Output-level expectations, updated by time-stamped events
   typedef struct {
      int         t;
      int         kind;   // 0: miso_en low, 1: miso_en high, 2: write commit
      logic [5:0] a;
      logic [7:0] d;
   } ev_t;
   ev_t        evq[$];
   ev_t        cmp_ev;
   logic [7:0] e_ctrl [0:4];
   logic       e_en, e_strobe;
   logic [5:0] e_wr_addr;
   bit         chk_en = 1'b0;

   logic [7:0] wbuf[$];
   logic [7:0] rx_log[$];
   bit         sv_at[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [5:0] a);
      if (a == 6'h0F) return 8'hD3;
      if (a >= 6'h20 && a <= 6'h24) return m_ctrl[3'(a - 6'h20)];
      if (a == 6'h27) return {m_or, 3'b000, m_da, 3'b000};
      case (a)
         6'h28: return m_sx[7:0];
         6'h29: return m_sx[15:8];
         6'h2A: return m_sy[7:0];
         6'h2B: return m_sy[15:8];
         6'h2C: return m_sz[7:0];
         6'h2D: return m_sz[15:8];
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      m_ctrl = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
      e_ctrl = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
      m_sx = '0; m_sy = '0; m_sz = '0;
      m_da = 1'b0; m_or = 1'b0;
      e_en = 1'b0; e_wr_addr = '0;
      evq.delete();
   endtask

   // Per-cycle compare against the event-driven expectations
   initial forever begin
      @(negedge clk);
      if (wr_strobe === 1'b1) n_strobe++;
      if (chk_en) begin
         e_strobe = 1'b0;
         while (evq.size() > 0 && evq[0].t <= cyc) begin
            cmp_ev = evq.pop_front();
            if (cmp_ev.kind == 2) begin
               e_strobe  = 1'b1;
               e_wr_addr = cmp_ev.a;
               e_ctrl[3'(cmp_ev.a - 6'h20)] = cmp_ev.d;
            end else begin
               e_en = (cmp_ev.kind == 1);
            end
         end
         check("miso_en", 64'(miso_en), 64'(e_en));
         check("wr_strobe", 64'(wr_strobe), 64'(e_strobe));
         check("wr_addr", 64'(wr_addr), 64'(e_wr_addr));
         check("ctrl_regs", {24'h0, c1, c2, c3, c4, c5},
               {24'h0, e_ctrl[0], e_ctrl[1], e_ctrl[2], e_ctrl[3], e_ctrl[4]});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input int kind, input logic [5:0] a, input logic [7:0] d);
      ev_t ev;
      ev.t = cyc + LAT; ev.kind = kind; ev.a = a; ev.d = d;
      evq.push_back(ev);
   endtask

   task automatic pulse_sample();
      x_data = sv_x; y_data = sv_y; z_data = sv_z;
      sample_valid = 1'b1;
      m_or = m_or | m_da;
      m_da = 1'b1;
      tick(1);
      sample_valid = 1'b0;
   endtask

   function automatic bit sv_get(input int i);
      return (i < sv_at.size()) ? sv_at[i] : 1'b0;
   endfunction

   task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit sv, input bit commit,
                           input logic [5:0] ca, output logic [7:0] rx);
      logic [7:0] sh;
      sh = tx;
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         mosi = sh[7];
         sh   = {sh[6:0], 1'b0};
         if (sv && i == 3) begin
            tick(2); pulse_sample(); tick(HALF - 3);
         end else begin
            tick(HALF);
         end
         rx   = {rx[6:0], miso};
         sclk = 1'b1;
         if (commit && i == 7) push_ev(2, ca, tx);
         tick(HALF);
      end
   endtask

   task automatic ss_begin();
      ss = 1'b0;
      push_ev(1, 6'h0, 8'h0);
      m_sx = x_data; m_sy = y_data; m_sz = z_data;
      m_da = 1'b0; m_or = 1'b0;
      tick(HALF);
   endtask

   task automatic ss_end();
      ss = 1'b1;
      push_ev(0, 6'h0, 8'h0);
      tick(2 * HALF);
   endtask

   // tail_bits < 8 aborts the last data byte after that many bits
   task automatic xfer(input logic [7:0] cmd, input int nbytes, input int tail_bits);
      logic [7:0] rx, exp;
      logic [5:0] a;
      bit         full, wr;
      rx_log.delete();
      ss_begin();
      spi_bits(cmd, 8, sv_get(0), 1'b0, 6'h0, rx);
      check("cmd_miso", 64'(rx), 64'h00);
      a = cmd[5:0];
      for (int b = 0; b < nbytes; b++) begin
         full = (b < nbytes - 1) || (tail_bits == 8);
         exp  = m_read(a);
         wr   = !cmd[7] && full && (a >= 6'h20) && (a <= 6'h24);
         spi_bits((b < wbuf.size()) ? wbuf[b] : 8'h00, full ? 8 : tail_bits, sv_get(b + 1),
                  wr, a, rx);
         rx_log.push_back(rx);
         if (cmd[7] && full) check("read_byte", 64'(rx), 64'(exp));
         if (wr) m_ctrl[3'(a - 6'h20)] = wbuf[b];
         if (cmd[6]) a = a + 6'd1;
      end
      ss_end();
      sv_at.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"}, 64'(miso), 64'h1);
      check({tag, "_miso_en"}, 64'(miso_en), 64'h0);
      check({tag, "_wr_strobe"}, 64'(wr_strobe), 64'h0);
      check({tag, "_wr_addr"}, 64'(wr_addr), 64'h0);
      check({tag, "_ctrl"}, {24'h0, c1, c2, c3, c4, c5}, 64'h07_00_00_00_00);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      logic [7:0] rx;
      logic [7:0] cmd;
      logic [5:0] addr;
      int nby, tail;

      model_reset();
      tick(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(3);
      chk_en = 1'b1;

      // WHO_AM_I
      xfer(8'h8F, 1, 8);
      check("who_am_i", 64'(rx_log[0]), 64'hD3);

      // Coherent burst read of the snapshot
      x_data = 16'h1234; y_data = 16'hABCD; z_data = 16'h8001;
      xfer(8'hE8, 6, 8);
      check("burst_xyz", {16'h0, rx_log[0], rx_log[1], rx_log[2], rx_log[3], rx_log[4], rx_log[5]},
            64'h0000_3412_CDAB_0180);

      // sample_valid mid-burst must not disturb the snapshot
      sv_x = 16'hFFFF; sv_y = 16'hABCD; sv_z = 16'h8001;
      x_data = 16'h1234;
      sv_at = '{1'b0, 1'b0, 1'b1};
      xfer(8'hE8, 6, 8);
      check("burst_held", {16'h0, rx_log[0], rx_log[1], rx_log[2], rx_log[3], rx_log[4], rx_log[5]},
            64'h0000_3412_CDAB_0180);
      sv_at = '{1'b1};
      xfer(8'hA7, 1, 8);
      check("status_da", 64'(rx_log[0]), 64'h08);
      sv_at = '{1'b1, 1'b1};
      xfer(8'hA7, 2, 8);
      check("status_or", {48'h0, rx_log[0], rx_log[1]}, 64'h0888);

      // Writes, including an auto-increment burst
      s0 = n_strobe;
      wbuf = '{8'h0F};
      xfer(8'h20, 1, 8);
      wbuf = '{8'h11, 8'h22};
      xfer(8'h63, 2, 8);
      check("wr_ctrl1", 64'(c1), 64'h0F);
      check("wr_ctrl4", 64'(c4), 64'h11);
      check("wr_ctrl5", 64'(c5), 64'h22);
      check("wr_count", 64'(n_strobe - s0), 64'd3);
      check("wr_last_addr", 64'(wr_addr), 64'h24);

      // Aborted write, then write to a read-only address
      s0 = n_strobe;
      wbuf = '{8'hAA};
      xfer(8'h21, 1, 5);
      check("abort_ctrl2", 64'(c2), 64'h00);
      wbuf = '{8'h55};
      xfer(8'h0F, 1, 8);
      check("ro_no_strobe", 64'(n_strobe - s0), 64'd0);
      xfer(8'h8F, 1, 8);
      check("ro_who_am_i", 64'(rx_log[0]), 64'hD3);

      // Address wrap 0x3F -> 0x00
      xfer(8'hFF, 3, 8);
      check("wrap_bytes", {40'h0, rx_log[0], rx_log[1], rx_log[2]}, 64'h0);

      // Randomized transactions against the model
      for (int r = 0; r < 30; r++) begin
         x_data = 16'($urandom); y_data = 16'($urandom); z_data = 16'($urandom);
         sv_x = 16'($urandom); sv_y = 16'($urandom); sv_z = 16'($urandom);
         case ($urandom_range(0, 5))
            0:       addr = 6'h0F;
            1:       addr = 6'h20 + 6'($urandom_range(0, 4));
            2:       addr = 6'h27;
            3:       addr = 6'h28 + 6'($urandom_range(0, 5));
            4:       addr = 6'h3D + 6'($urandom_range(0, 2));
            default: addr = 6'($urandom);
         endcase
         cmd  = {1'($urandom), 1'($urandom), addr};
         nby  = $urandom_range(1, 4);
         tail = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 8;
         wbuf.delete();
         sv_at.delete();
         for (int b = 0; b <= nby; b++) begin
            wbuf.push_back(8'($urandom));
            sv_at.push_back($urandom_range(0, 3) == 0);
         end
         xfer(cmd, nby, tail);
      end

      // Reset in the middle of a byte
      wbuf = '{8'h5A};
      xfer(8'h20, 1, 8);
      ss_begin();
      spi_bits(8'h8F, 8, 1'b0, 1'b0, 6'h0, rx);
      spi_bits(8'h00, 3, 1'b0, 1'b0, 6'h0, rx);
      sclk = 1'b0;
      tick(2);
      rst_n  = 1'b0;
      chk_en = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      ss = 1'b1;
      sclk = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(3);
      chk_en = 1'b1;
      xfer(8'hA0, 1, 8);
      check("post_rst_ctrl1", 64'(rx_log[0]), 64'h07);

      tick(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
